// File: rtl/inttofloat.sv
// -----------------------------------------------------------------------------
// inttofloat
//
// Converts a signed 16-bit two's-complement sample into an IEEE-754
// single-precision float. The magnitude is normalised one bit per clock:
// it is shifted left until its MSB is set, and the exponent is decremented
// once per shift. Every 16-bit integer fits exactly in a 24-bit significand,
// so no rounding is ever needed.
//
// A start/busy/done handshake allows one instance to be time-shared by a
// sequencer.
//
// Ports
//   clk       in   1   rising-edge clock
//   reset     in   1   asynchronous, active-low reset (0 = in reset)
//   start     in   1   conversion request, sampled only while idle
//   intin     in  16   signed operand, captured on the accepting edge
//   floatout  out 32   {sign, exp[7:0], frac[22:0]}; held until the next result
//   busy      out  1   high while normalising
//   done      out  1   floatout is valid for the last accepted start
//
// Latency: a zero operand completes on the accepting edge. A nonzero operand
// whose magnitude has its MSB at bit k completes 16-k edges after the
// accepting edge. The worst case is 17 edges in total.
// -----------------------------------------------------------------------------
module inttofloat (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] intin,
    output logic [31:0] floatout,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        NORM = 1'b1
    } state_t;

    // 127 (bias) + 15: the exponent of a magnitude whose MSB is already at bit 15.
    localparam logic [7:0] EXP_START = 8'd142;

    state_t      state_reg, state_next;
    logic        sign_reg,  sign_next;
    logic [15:0] mag_reg,   mag_next;
    logic [7:0]  exp_reg,   exp_next;
    logic [31:0] float_reg, float_next;
    logic        done_reg,  done_next;

    // Absolute value of the operand.
    // -32768 negates to 0x8000, which is the correct unsigned magnitude.
    logic [15:0] abs_in;
    assign abs_in = intin[15] ? (~intin + 16'd1) : intin;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            sign_reg  <= 1'b0;
            mag_reg   <= 16'd0;
            exp_reg   <= 8'd0;
            float_reg <= 32'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sign_reg  <= sign_next;
            mag_reg   <= mag_next;
            exp_reg   <= exp_next;
            float_reg <= float_next;
            done_reg  <= done_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        sign_next  = sign_reg;
        mag_next   = mag_reg;
        exp_next   = exp_reg;
        float_next = float_reg;
        done_next  = done_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    done_next = 1'b0;
                    sign_next = intin[15];
                    mag_next  = abs_in;
                    exp_next  = EXP_START;
                    if (intin == 16'd0) begin
                        // Zero has no leading one to normalise. It finishes on
                        // the accepting edge and always yields positive zero.
                        sign_next  = 1'b0;
                        float_next = 32'd0;
                        done_next  = 1'b1;
                    end else begin
                        state_next = NORM;
                    end
                end
            end

            NORM: begin
                if (mag_reg[15]) begin
                    // The leading one becomes the implicit bit. The remaining
                    // 15 bits are the top of the 23-bit fraction.
                    float_next = {sign_reg, exp_reg, mag_reg[14:0], 8'b0};
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    mag_next = {mag_reg[14:0], 1'b0};
                    exp_next = exp_reg - 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign floatout = float_reg;
    assign done     = done_reg;
    assign busy     = (state_reg == NORM);

endmodule

// File: tb/tb_inttofloat.sv
// -----------------------------------------------------------------------------
// Bench for inttofloat.
//
// The stimulus process pushes the expected float and latency for every start
// it expects to be accepted. A separate monitor watches the DUT pins on the
// falling edge and pops one entry from the queue for each result it sees.
//
// A result is detected when done rises, or when done is high right after an
// accepting edge (the zero-operand case, where done stays high).
//
// For each result the monitor checks three things:
//   - the float value,
//   - the edge count from the accepting edge,
//   - the number of cycles busy was high.
// -----------------------------------------------------------------------------
module tb_inttofloat;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] intin;
    logic [31:0] floatout;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] value;
        int          latency;
        logic [15:0] operand;
    } exp_t;

    exp_t sb[$];

    inttofloat dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .intin    (intin),
        .floatout (floatout),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model. It finds the leading one directly rather than by
    // shifting, so it does not share a structure with the DUT.
    // -------------------------------------------------------------------------
    function automatic exp_t model(input logic [15:0] x);
        exp_t        r;
        logic [15:0] a;
        logic [31:0] ext;
        int          k;

        r.operand = x;
        if (x == 16'd0) begin
            r.value   = 32'd0;
            r.latency = 0;
            return r;
        end

        a = x[15] ? (16'd0 - x) : x;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (a[i]) k = i;
        end

        ext       = {16'd0, a} << (23 - k);
        r.value   = {x[15], 8'(127 + k), ext[22:0]};
        r.latency = 16 - k;
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    initial begin
        logic acc_pend;
        logic prev_done;
        logic active;
        int   cnt;
        int   bcnt;
        exp_t e;

        acc_pend  = 1'b0;
        prev_done = 1'b0;
        active    = 1'b0;
        cnt       = 0;
        bcnt      = 0;

        forever begin
            @(negedge clk);
            if (!reset) begin
                acc_pend  = 1'b0;
                prev_done = 1'b0;
                active    = 1'b0;
                continue;
            end

            if (acc_pend) begin
                active = 1'b1;
                cnt    = 0;
                bcnt   = 0;
            end else if (active) begin
                cnt++;
            end
            if (busy) bcnt++;

            if (done && (!prev_done || acc_pend)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got floatout=%08h with no pending conversion", floatout);
                end else begin
                    e = sb.pop_front();

                    checks++;
                    if (floatout !== e.value) begin
                        errors++;
                        $display("FAIL value(%04h): got %08h expected %08h", e.operand, floatout, e.value);
                    end

                    checks++;
                    if (cnt != e.latency) begin
                        errors++;
                        $display("FAIL latency(%04h): got edge %0d expected edge %0d", e.operand, cnt, e.latency);
                    end

                    checks++;
                    if (bcnt != e.latency || busy !== 1'b0) begin
                        errors++;
                        $display("FAIL busy(%04h): busy cycles %0d (busy now %b) expected %0d (busy now 0)",
                                 e.operand, bcnt, busy, e.latency);
                    end

                    $display("result intin=%04h floatout=%08h edge=%0d busy_cycles=%0d",
                             e.operand, floatout, cnt, bcnt);
                end
                active = 1'b0;
            end

            prev_done = done;
            acc_pend  = start && !busy;
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d result(s) still pending after %0d cycles", sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic convert_exp(input logic [15:0] x, input logic [31:0] v, input int lat);
        exp_t e;
        e.value   = v;
        e.latency = lat;
        e.operand = x;

        @(posedge clk);
        #2;
        start = 1'b1;
        intin = x;
        sb.push_back(e);

        @(posedge clk);
        #2;
        start = 1'b0;
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string nm);
        checks++;
        if (floatout !== 32'd0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got floatout=%08h done=%b busy=%b expected 00000000/0/0",
                     nm, floatout, done, busy);
        end
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        exp_t e;
        exp_t e2;

        reset = 1'b0;
        start = 1'b0;
        intin = 16'd0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");

        @(posedge clk);
        #2;
        reset = 1'b1;

        // Directed vectors with hand-computed results: operand, float, latency.
        convert_exp(16'h0001, 32'h3F800000, 16);
        convert_exp(16'hFFFF, 32'hBF800000, 16);
        convert_exp(16'd100,  32'h42C80000, 10);
        convert_exp(16'hFF9C, 32'hC2C80000, 10);   // -100
        convert_exp(16'h7FFF, 32'h46FFFE00, 2);
        convert_exp(16'h8000, 32'hC7000000, 1);
        convert_exp(16'h0003, 32'h40400000, 15);
        convert_exp(16'hFFFE, 32'hC0000000, 15);   // -2

        // Zero, then the most negative value, so a stale zero cannot be reused.
        convert_exp(16'h0000, 32'h00000000, 0);
        convert_exp(16'h8000, 32'hC7000000, 1);

        // Zero twice in a row: done stays high but each one is a new result.
        convert_exp(16'h0000, 32'h00000000, 0);
        convert_exp(16'h0000, 32'h00000000, 0);

        // A start pulsed at edge 4 while busy must be ignored.
        e.value   = 32'h3F800000;
        e.latency = 16;
        e.operand = 16'h0001;
        @(posedge clk);
        #2;
        start = 1'b1;
        intin = 16'h0001;
        sb.push_back(e);
        repeat (4) @(posedge clk);                 // edges 0..3
        #2;
        start = 1'b1;                              // seen at edge 4
        intin = 16'h0005;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_idle();
        convert_exp(16'h0005, 32'h40A00000, 14);

        // Holding start high: a new start is accepted on the edge right after done.
        e.value    = 32'h46800000;
        e.latency  = 2;
        e.operand  = 16'h4000;
        e2.value   = 32'hC6800000;
        e2.latency = 2;
        e2.operand = 16'hC000;                     // -16384
        @(posedge clk);
        #2;
        start = 1'b1;
        intin = 16'h4000;
        sb.push_back(e);
        repeat (3) @(posedge clk);                 // edges 0,1,2 (done at 2)
        #2;
        intin = 16'hC000;                          // accepted at edge 3
        sb.push_back(e2);
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_idle();

        // Asynchronous reset at edge 3 of a conversion abandons it.
        @(posedge clk);
        #2;
        start = 1'b1;
        intin = 16'h0001;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset_midconv");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("after_reset_release");
        convert_exp(16'h0001, 32'h3F800000, 16);

        // Random sweep against the model.
        for (int i = 0; i < 2000; i++) begin
            e = model(16'($urandom_range(0, 65535)));
            convert_exp(e.operand, e.value, e.latency);
        end

        repeat (20) @(posedge clk);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
